e_pipe_reg: RTL and testbench
=============================

Name: e_pipe_reg

Overview:
- Decode-to-execute pipeline register of the 5-stage RISC-V core.
- Captures the decoded instruction and its two forwarded operand values, which are produced by the per-operand forwarding selectors in D.
- Detects load-use hazards against the instruction currently in E and inserts a one-cycle bubble while stalling F/D.
- Also handles mispredict flush from E and a global memory stall hold.

Parameters:
- XLEN, 32, data/address width.
- BUBBLE_OP, 7'b0000000, opcode written for a bubble; must not be a register-writing opcode.

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  async active-low reset.
- d_valid_i  in  1  D holds a real instruction.
- d_opcode_i  in  7  decoded opcode.
- d_rd_i  in  5  destination register.
- d_rs1_i  in  5  source register 1 index.
- d_rs2_i  in  5  source register 2 index.
- d_funct3_i  in  3  funct3 field.
- d_funct7_i  in  7  funct7 field.
- d_imm_i  in  XLEN  sign-extended immediate.
- d_pc_i  in  XLEN  instruction PC.
- d_default_pc_i  in  XLEN  PC+4.
- d_fwd_val1_i  in  XLEN  forwarded rs1 value.
- d_fwd_val2_i  in  XLEN  forwarded rs2 value.
- e_flush_i  in  1  branch/jump mispredict resolved in E.
- m_stall_i  in  1  data memory busy; freeze whole pipe.
- E_valid_o  out  1  E holds a real instruction.
- E_opcode_o  out  7  registered opcode.
- E_rd_o  out  5  registered rd.
- E_funct3_o  out  3  registered funct3.
- E_funct7_o  out  7  registered funct7.
- E_imm_o  out  XLEN  registered immediate.
- E_pc_o  out  XLEN  registered PC.
- E_default_pc_o  out  XLEN  registered PC+4.
- E_valA_o  out  XLEN  registered operand 1.
- E_valB_o  out  XLEN  registered operand 2.
- ld_use_stall_o  out  1  combinational; hold F and D this cycle.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - All outputs cleared to 0.
  - E_opcode_o set to BUBBLE_OP.
  - E_valid_o=0.
  - Release is synchronous to the next clk_i rising edge.
- rs usage decoded from d_opcode_i:
  - uses_rs1 for JALR, BRANCH, LOAD, STORE, IMM, R.
  - uses_rs2 for BRANCH, STORE, R.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- ld_use_stall_o = d_valid_i & E_valid_o & (E_opcode_o==OP_LOAD) & (E_rd_o!=0) & ((uses_rs1 & d_rs1_i==E_rd_o) | (uses_rs2 & d_rs2_i==E_rd_o)).
  - Forced 0 when e_flush_i=1, because the D instruction is being discarded.
- Per-edge priority, highest first:
  1. m_stall_i=1: hold all registers unchanged, even if e_flush_i or a hazard is present. ld_use_stall_o is still evaluated normally.
  2. e_flush_i=1: load a bubble (E_valid_o=0, opcode=BUBBLE_OP, rd=0, other fields 0).
  3. ld_use_stall_o=1: load a bubble; D contents are untouched upstream.
  4. d_valid_i=0: load a bubble.
  5. Otherwise: capture all d_* fields, d_fwd_val1_i→E_valA_o, d_fwd_val2_i→E_valB_o, E_valid_o=1.
- Latency: 1 cycle from D to E.
- Load-use bubble lasts exactly one cycle. On the next edge the load is in M and the dependent operand is forwarded from the M-stage load-data path.
- A bubble carries rd=0 and a non-writing opcode, so the forwarding selectors never match it.
- x0 destination: a load with rd=0 never triggers a stall.
- Back-to-back loads to the same rd: each dependent instruction stalls independently; no stall accumulation.
- Flush concurrent with a hazard: flush wins, and the stall output is low.

Optional Feature:
- Macro E_PIPE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_bubble_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_bubble_cnt_o increments on each edge where a load-use bubble is inserted (not during m_stall_i).
  - perf_flush_cnt_o increments on each flush edge.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define.v: OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_R, OP_IMM, OP_LUI, OP_AUIPC, plus a new OP_BUBBLE (=BUBBLE_OP default).
- One natural sub-module: ld_use_det, the combinational uses_rs decode plus the hazard compare. It is reused by the F/D register hold logic.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst_n_i low between edges while E holds ADD x5.
  - Response: outputs clear immediately, E_valid_o=0, E_opcode_o=0.
- Normal capture:
  - Stimulus: d_opcode=OP_R, rd=3, fwd1=0x11, fwd2=0x22.
  - Response: next edge E_valA_o=0x11, E_valB_o=0x22, E_rd_o=3, E_valid_o=1.
- Load-use:
  - Stimulus: E holds LW x5, D presents ADD x6,x5,x7.
  - Response: ld_use_stall_o=1, next edge E bubble. Following edge ADD is captured and ld_use_stall_o=0.
- No false stall, two cases:
  - E holds LW x0, D presents ADD x1,x0,x0 → no stall.
  - E holds LW x5, D presents LUI x5 → no stall.
- Flush vs hazard:
  - Stimulus: e_flush_i=1 with a load-use condition present.
  - Response: ld_use_stall_o=0, E bubble.
- m_stall hold:
  - Stimulus: m_stall_i=1 for 3 cycles with e_flush_i pulsed.
  - Response: E registers unchanged throughout. With E_PIPE_PERF_CNT_EN, neither counter increments.

Source files
------------

// File: rtl/e_pipe_reg_pkg.sv
// Shared opcode map and E-stage control bundle for the D/E pipeline register.
// Used by e_pipe_reg and its load-use detector.
package e_pipe_reg_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BUBBLE = 7'b0000000;

    typedef struct packed {
        logic       valid;
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } ex_ctrl_t;

    // A bubble never writes a register: rd=0 and a non-writing opcode.
    function automatic ex_ctrl_t bubble_ctrl(input logic [6:0] op);
        ex_ctrl_t c;
        c        = '0;
        c.opcode = op;
        return c;
    endfunction

endpackage

// File: rtl/e_pipe_reg_ld_use.sv
// Load-use hazard detector: decodes which sources D reads and compares
// them against a load sitting in E. Also reused by the F/D hold logic.
module e_pipe_reg_ld_use
    import e_pipe_reg_pkg::*;
(
    input  logic       d_valid_i,
    input  logic [6:0] d_opcode_i,
    input  logic [4:0] d_rs1_i,
    input  logic [4:0] d_rs2_i,
    input  logic       e_valid_i,
    input  logic [6:0] e_opcode_i,
    input  logic [4:0] e_rd_i,
    input  logic       e_flush_i,
    output logic       ld_use_stall_o
);

    logic uses_rs1;
    logic uses_rs2;
    logic e_is_load;
    logic hit;

    // Source-register usage by opcode; unknown opcodes read nothing.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (d_opcode_i)
            OP_JALR, OP_LOAD, OP_IMM: uses_rs1 = 1'b1;
            OP_BRANCH, OP_STORE, OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // A flushed D instruction is discarded, so it can never stall.
    always_comb begin
        e_is_load = e_valid_i && (e_opcode_i == OP_LOAD) && (e_rd_i != 5'd0);
        hit = (uses_rs1 && (d_rs1_i == e_rd_i)) ||
              (uses_rs2 && (d_rs2_i == e_rd_i));
        ld_use_stall_o = d_valid_i && e_is_load && hit && !e_flush_i;
    end

endmodule

// File: rtl/e_pipe_reg.sv
// Decode-to-execute pipeline register with load-use bubble, flush and hold.
// Optional perf counters are built when E_PIPE_PERF_CNT_EN is defined.
module e_pipe_reg
    import e_pipe_reg_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter logic [6:0] BUBBLE_OP = OP_BUBBLE
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            d_valid_i,
    input  logic [6:0]      d_opcode_i,
    input  logic [4:0]      d_rd_i,
    input  logic [4:0]      d_rs1_i,
    input  logic [4:0]      d_rs2_i,
    input  logic [2:0]      d_funct3_i,
    input  logic [6:0]      d_funct7_i,
    input  logic [XLEN-1:0] d_imm_i,
    input  logic [XLEN-1:0] d_pc_i,
    input  logic [XLEN-1:0] d_default_pc_i,
    input  logic [XLEN-1:0] d_fwd_val1_i,
    input  logic [XLEN-1:0] d_fwd_val2_i,
    input  logic            e_flush_i,
    input  logic            m_stall_i,
    output logic            E_valid_o,
    output logic [6:0]      E_opcode_o,
    output logic [4:0]      E_rd_o,
    output logic [2:0]      E_funct3_o,
    output logic [6:0]      E_funct7_o,
    output logic [XLEN-1:0] E_imm_o,
    output logic [XLEN-1:0] E_pc_o,
    output logic [XLEN-1:0] E_default_pc_o,
    output logic [XLEN-1:0] E_valA_o,
    output logic [XLEN-1:0] E_valB_o,
    output logic            ld_use_stall_o
`ifdef E_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_bubble_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);

    ex_ctrl_t        e_ctrl;
    logic [XLEN-1:0] e_imm;
    logic [XLEN-1:0] e_pc;
    logic [XLEN-1:0] e_dpc;
    logic [XLEN-1:0] e_va;
    logic [XLEN-1:0] e_vb;
    logic            load_bubble;

    e_pipe_reg_ld_use u_ld_use (
        .d_valid_i      (d_valid_i),
        .d_opcode_i     (d_opcode_i),
        .d_rs1_i        (d_rs1_i),
        .d_rs2_i        (d_rs2_i),
        .e_valid_i      (e_ctrl.valid),
        .e_opcode_i     (e_ctrl.opcode),
        .e_rd_i         (e_ctrl.rd),
        .e_flush_i      (e_flush_i),
        .ld_use_stall_o (ld_use_stall_o)
    );

    assign load_bubble = e_flush_i || ld_use_stall_o || !d_valid_i;

    // E register: memory stall holds, else bubble or capture D.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e_ctrl <= bubble_ctrl(BUBBLE_OP);
            e_imm  <= '0;
            e_pc   <= '0;
            e_dpc  <= '0;
            e_va   <= '0;
            e_vb   <= '0;
        end else if (!m_stall_i) begin
            if (load_bubble) begin
                e_ctrl <= bubble_ctrl(BUBBLE_OP);
                e_imm  <= '0;
                e_pc   <= '0;
                e_dpc  <= '0;
                e_va   <= '0;
                e_vb   <= '0;
            end else begin
                e_ctrl <= '{valid:  1'b1,
                            opcode: d_opcode_i,
                            rd:     d_rd_i,
                            funct3: d_funct3_i,
                            funct7: d_funct7_i};
                e_imm  <= d_imm_i;
                e_pc   <= d_pc_i;
                e_dpc  <= d_default_pc_i;
                e_va   <= d_fwd_val1_i;
                e_vb   <= d_fwd_val2_i;
            end
        end
    end

    assign E_valid_o      = e_ctrl.valid;
    assign E_opcode_o     = e_ctrl.opcode;
    assign E_rd_o         = e_ctrl.rd;
    assign E_funct3_o     = e_ctrl.funct3;
    assign E_funct7_o     = e_ctrl.funct7;
    assign E_imm_o        = e_imm;
    assign E_pc_o         = e_pc;
    assign E_default_pc_o = e_dpc;
    assign E_valA_o       = e_va;
    assign E_valB_o       = e_vb;

`ifdef E_PIPE_PERF_CNT_EN
    // Count inserted load-use bubbles and flushes; frozen during m_stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_bubble_cnt_o <= '0;
            perf_flush_cnt_o  <= '0;
        end else if (!m_stall_i) begin
            if (e_flush_i)
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            else if (ld_use_stall_o)
                perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
        end
    end
`else
    // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_e_pipe_reg.sv
// Self-checking bench for e_pipe_reg: a behavioural model predicts each
// E-stage state into a queue that is popped after every clock edge.
module tb_e_pipe_reg;

    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] RR   = 7'b0110011;
    localparam logic [6:0] IMM  = 7'b0010011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] BUB  = 7'b0000000;

    typedef struct packed {
        logic        v;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] dpc;
        logic [31:0] a;
        logic [31:0] b;
    } e_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        d_valid_i = 1'b0;
    logic [6:0]  d_opcode_i = '0;
    logic [4:0]  d_rd_i = '0;
    logic [4:0]  d_rs1_i = '0;
    logic [4:0]  d_rs2_i = '0;
    logic [2:0]  d_funct3_i = '0;
    logic [6:0]  d_funct7_i = '0;
    logic [31:0] d_imm_i = '0;
    logic [31:0] d_pc_i = '0;
    logic [31:0] d_default_pc_i = '0;
    logic [31:0] d_fwd_val1_i = '0;
    logic [31:0] d_fwd_val2_i = '0;
    logic        e_flush_i = 1'b0;
    logic        m_stall_i = 1'b0;
    logic        E_valid_o;
    logic [6:0]  E_opcode_o;
    logic [4:0]  E_rd_o;
    logic [2:0]  E_funct3_o;
    logic [6:0]  E_funct7_o;
    logic [31:0] E_imm_o;
    logic [31:0] E_pc_o;
    logic [31:0] E_default_pc_o;
    logic [31:0] E_valA_o;
    logic [31:0] E_valB_o;
    logic        ld_use_stall_o;
`ifdef E_PIPE_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt_o;
    logic [31:0] perf_flush_cnt_o;
    logic [31:0] m_pb = '0;
    logic [31:0] m_pf = '0;
`endif

    int vecs = 0;
    int errs = 0;
    e_t sb[$];
    e_t m_e = '0;

    always #5 clk_i = ~clk_i;

    e_pipe_reg dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .d_valid_i      (d_valid_i),
        .d_opcode_i     (d_opcode_i),
        .d_rd_i         (d_rd_i),
        .d_rs1_i        (d_rs1_i),
        .d_rs2_i        (d_rs2_i),
        .d_funct3_i     (d_funct3_i),
        .d_funct7_i     (d_funct7_i),
        .d_imm_i        (d_imm_i),
        .d_pc_i         (d_pc_i),
        .d_default_pc_i (d_default_pc_i),
        .d_fwd_val1_i   (d_fwd_val1_i),
        .d_fwd_val2_i   (d_fwd_val2_i),
        .e_flush_i      (e_flush_i),
        .m_stall_i      (m_stall_i),
        .E_valid_o      (E_valid_o),
        .E_opcode_o     (E_opcode_o),
        .E_rd_o         (E_rd_o),
        .E_funct3_o     (E_funct3_o),
        .E_funct7_o     (E_funct7_o),
        .E_imm_o        (E_imm_o),
        .E_pc_o         (E_pc_o),
        .E_default_pc_o (E_default_pc_o),
        .E_valA_o       (E_valA_o),
        .E_valB_o       (E_valB_o),
        .ld_use_stall_o (ld_use_stall_o)
`ifdef E_PIPE_PERF_CNT_EN
        ,
        .perf_bubble_cnt_o (perf_bubble_cnt_o),
        .perf_flush_cnt_o  (perf_flush_cnt_o)
`endif
    );

    function automatic e_t dut_e();
        return '{E_valid_o, E_opcode_o, E_rd_o, E_funct3_o, E_funct7_o,
                 E_imm_o, E_pc_o, E_default_pc_o, E_valA_o, E_valB_o};
    endfunction

    function automatic e_t bubble();
        e_t b;
        b    = '0;
        b.op = BUB;
        return b;
    endfunction

    function automatic logic model_stall();
        logic r1;
        logic r2;
        r1 = d_opcode_i inside {JALR, BR, LD, ST, IMM, RR};
        r2 = d_opcode_i inside {BR, ST, RR};
        if (!d_valid_i || e_flush_i) return 1'b0;
        if (!(m_e.v && m_e.op == LD && m_e.rd != 5'd0)) return 1'b0;
        return (r1 && d_rs1_i == m_e.rd) || (r2 && d_rs2_i == m_e.rd);
    endfunction

    // Drive one D-stage vector, predict, clock, and hand back results.
    task automatic run(input logic v, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] va,
                       input logic [31:0] vb, input logic fl,
                       input logic ms, output logic gs, output logic es,
                       output e_t ge, output e_t ee);
        e_t nx;
        d_valid_i      = v;
        d_opcode_i     = op;
        d_rd_i         = rd;
        d_rs1_i        = rs1;
        d_rs2_i        = rs2;
        d_funct3_i     = 3'($urandom);
        d_funct7_i     = 7'($urandom);
        d_imm_i        = $urandom;
        d_pc_i         = $urandom;
        d_default_pc_i = d_pc_i + 32'd4;
        d_fwd_val1_i   = va;
        d_fwd_val2_i   = vb;
        e_flush_i      = fl;
        m_stall_i      = ms;
        #1;
        gs = ld_use_stall_o;
        es = model_stall();
        if (ms) nx = m_e;
        else if (fl || es || !v) nx = bubble();
        else nx = '{1'b1, op, rd, d_funct3_i, d_funct7_i, d_imm_i,
                    d_pc_i, d_default_pc_i, va, vb};
`ifdef E_PIPE_PERF_CNT_EN
        if (!ms && fl) m_pf = m_pf + 1;
        else if (!ms && es) m_pb = m_pb + 1;
`endif
        sb.push_back(nx);
        m_e = nx;
        @(posedge clk_i);
        #1;
        ge = dut_e();
        ee = sb.pop_front();
    endtask

    task automatic test_reset();
        e_t g;
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        g = dut_e();
        vecs++;
        if (g !== bubble() || ld_use_stall_o !== 1'b0) begin
            errs++;
            $display("FAIL reset: got %h stall %b, want %h stall 0",
                     g, ld_use_stall_o, bubble());
        end
        rst_n_i = 1'b1;
        m_e = bubble();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_capture();
        logic gs, es;
        e_t ge, ee;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: run(1, RR, 3, 1, 2, 32'h11, 32'h22, 0, 0, gs, es, ge, ee);
                1: run(1, IMM, 9, 4, 0, $urandom, $urandom, 0, 0, gs, es, ge, ee);
                2: run(1, ST, 0, 7, 8, $urandom, $urandom, 0, 0, gs, es, ge, ee);
                default: run(0, RR, 4, 1, 1, $urandom, $urandom, 0, 0, gs, es, ge, ee);
            endcase
            vecs++;
            if (ge !== ee || gs !== es) begin
                errs++;
                $display("FAIL capture%0d: got %h/%b want %h/%b",
                         i, ge, gs, ee, es);
            end
        end
    endtask

    task automatic test_load_use();
        logic gs, es;
        e_t ge, ee;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: run(1, LD, 5, 1, 0, 1, 2, 0, 0, gs, es, ge, ee);
                1: run(1, RR, 6, 5, 7, 3, 4, 0, 0, gs, es, ge, ee);
                2: run(1, RR, 6, 5, 7, 3, 4, 0, 0, gs, es, ge, ee);
                3: run(1, LD, 9, 2, 0, 5, 6, 0, 0, gs, es, ge, ee);
                4: run(1, ST, 0, 3, 9, 7, 8, 0, 0, gs, es, ge, ee);
                default: run(1, ST, 0, 3, 9, 7, 8, 0, 0, gs, es, ge, ee);
            endcase
            vecs++;
            if (ge !== ee || gs !== es) begin
                errs++;
                $display("FAIL load_use%0d: got %h/%b want %h/%b",
                         i, ge, gs, ee, es);
            end
        end
    endtask

    task automatic test_no_false_stall();
        logic gs, es;
        e_t ge, ee;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: run(1, LD, 0, 1, 0, 1, 1, 0, 0, gs, es, ge, ee);
                1: run(1, RR, 1, 0, 0, 2, 2, 0, 0, gs, es, ge, ee);
                2: run(1, LD, 5, 1, 0, 3, 3, 0, 0, gs, es, ge, ee);
                3: run(1, LUI, 5, 5, 5, 4, 4, 0, 0, gs, es, ge, ee);
                4: run(1, LD, 5, 1, 0, 3, 3, 0, 0, gs, es, ge, ee);
                default: run(0, RR, 6, 5, 5, 4, 4, 0, 0, gs, es, ge, ee);
            endcase
            vecs++;
            if (ge !== ee || gs !== es) begin
                errs++;
                $display("FAIL no_stall%0d: got %h/%b want %h/%b",
                         i, ge, gs, ee, es);
            end
        end
    endtask

    task automatic test_flush_hazard();
        logic gs, es;
        e_t ge, ee;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: run(1, LD, 5, 1, 0, 1, 1, 0, 0, gs, es, ge, ee);
                1: run(1, RR, 6, 5, 5, 2, 2, 1, 0, gs, es, ge, ee);
                default: run(1, IMM, 7, 2, 0, 3, 3, 1, 0, gs, es, ge, ee);
            endcase
            vecs++;
            if (ge !== ee || gs !== es) begin
                errs++;
                $display("FAIL flush%0d: got %h/%b want %h/%b",
                         i, ge, gs, ee, es);
            end
        end
    endtask

    task automatic test_mstall();
        logic gs, es;
        e_t ge, ee;
`ifdef E_PIPE_PERF_CNT_EN
        logic [31:0] pb0, pf0;
`endif
        run(1, LD, 5, 1, 0, 9, 9, 0, 0, gs, es, ge, ee);
        vecs++;
        if (ge !== ee) begin
            errs++;
            $display("FAIL mstall_pre: got %h want %h", ge, ee);
        end
`ifdef E_PIPE_PERF_CNT_EN
        pb0 = perf_bubble_cnt_o;
        pf0 = perf_flush_cnt_o;
`endif
        for (int i = 0; i < 4; i++) begin
            run(1, RR, 6, 5, 1, 7, 7, i == 1, i < 3, gs, es, ge, ee);
            vecs++;
            if (ge !== ee || gs !== es) begin
                errs++;
                $display("FAIL mstall%0d: got %h/%b want %h/%b",
                         i, ge, gs, ee, es);
            end
`ifdef E_PIPE_PERF_CNT_EN
            if (i == 2) begin
                vecs++;
                if (perf_bubble_cnt_o !== pb0 || perf_flush_cnt_o !== pf0) begin
                    errs++;
                    $display("FAIL mstall_cnt: got %0d/%0d want %0d/%0d",
                             perf_bubble_cnt_o, perf_flush_cnt_o, pb0, pf0);
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic gs, es;
        e_t ge, ee;
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: run(1, LD, 5, 1, 0, 1, 1, 0, 0, gs, es, ge, ee);
                default: run(1, BR, 0, 2, 5, 4, 4, 0, 0, gs, es, ge, ee);
            endcase
            vecs++;
            if (ge !== ee || gs !== es) begin
                errs++;
                $display("FAIL b2b%0d: got %h/%b want %h/%b",
                         i, ge, gs, ee, es);
            end
        end
`ifdef E_PIPE_PERF_CNT_EN
        vecs++;
        if (perf_bubble_cnt_o !== m_pb || perf_flush_cnt_o !== m_pf) begin
            errs++;
            $display("FAIL perf_cnt: got %0d/%0d want %0d/%0d",
                     perf_bubble_cnt_o, perf_flush_cnt_o, m_pb, m_pf);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        logic gs, es;
        e_t ge, ee;
        run(1, RR, 5, 1, 2, 32'hAA, 32'hBB, 0, 0, gs, es, ge, ee);
        vecs++;
        if (ge !== ee || ge.v !== 1'b1) begin
            errs++;
            $display("FAIL add_x5: got %h want %h", ge, ee);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        ge = dut_e();
        vecs++;
        if (ge !== bubble()) begin
            errs++;
            $display("FAIL reset_mid: got %h want %h", ge, bubble());
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        m_e = bubble();
`ifdef E_PIPE_PERF_CNT_EN
        m_pb = '0;
        m_pf = '0;
`endif
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_no_false_stall();
        test_flush_hazard();
        test_mstall();
        test_back_to_back();
        test_reset_midstream();
        test_capture();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
